uart_rx_8n1: RTL and testbench
==============================

# uart_rx_8n1

Serial receiver sitting directly upstream of the PicoBlaze UART/7-segment design. Takes the raw `uart_rx_i` pin, recovers 8N1 frames at 115200 baud from the 50 MHz board clock, and presents each byte LSB-first-assembled on a valid/ready port to the consumer (PicoBlaze input port or CRC word assembler). Detects start-bit glitches, framing errors and overruns; optional FIFO decouples the consumer from byte arrival.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434: clock cycles per bit (50 MHz / 115200, truncated); minimum 8.
- `FIFO_DEPTH`, 4: byte FIFO depth, power of two. Used only with `UART_RX_FIFO_EN`.

Ports:
- `clk_50m`  in  1  system clock; all logic on its rising edge.
- `sw_rst_n`  in  1  **asynchronous, active-low reset** (one clock, async active-low reset).
- `uart_rx_i`  in  1  asynchronous serial line; idle high.
- `rx_data_o`  out  8  received byte; valid only while `rx_valid_o`=1.
- `rx_valid_o`  out  1  byte available.
- `rx_ready_i`  in  1  consumer accepts; a transfer happens on a cycle with valid&ready.
- `frame_err_o`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun_o`  out  1  one-cycle pulse: byte completed with no room; new byte dropped.
- `busy_o`  out  1  high from start-edge detection until return to IDLE.

## Operation
- Input passes through a 2-flop synchronizer, both flops reset to 1; a third flop holds the previous synced value for edge detection.
- Bit counter 3 bits, cycle counter `$clog2(CLKS_PER_BIT)` bits; shift register shifts right, new bit in at [7].
- FSM states:
  - IDLE: synced line falls (prev=1, cur=0) -> START, counter cleared.
  - START: after `CLKS_PER_BIT/2` cycles sample; 0 -> DATA, 1 -> IDLE (glitch, no output, no error).
  - DATA: every `CLKS_PER_BIT` cycles sample one bit; after bit 7 -> STOP.
  - STOP: after `CLKS_PER_BIT` cycles sample; 1 -> deliver byte, IDLE; 0 -> `frame_err_o` pulse, byte discarded, -> BREAK.
  - BREAK: wait for synced line = 1, then IDLE (a held-low line raises exactly one error).
- Delivery: if storage has room, byte stored; else `overrun_o` pulses and the stored data is unchanged (oldest data kept).
- Delivery and consumer pop in the same cycle: pop first, so a full store accepts the new byte with no overrun.
- Reset mid-frame: FSM to IDLE, storage emptied, partial byte lost; no pulses.

## Timing
- Reset values: `rx_data_o`=0, `rx_valid_o`=0, `frame_err_o`=0, `overrun_o`=0, `busy_o`=0.
- Edge detected 3 cycles after the pin falls. START sample `CLKS_PER_BIT/2` cycles later (217); data bit n sampled `(n+1)*CLKS_PER_BIT` after that; stop sample at `9*CLKS_PER_BIT`.
- `rx_valid_o` rises the cycle after the stop sample; `frame_err_o`/`overrun_o` assert that same cycle for one cycle.
- `rx_valid_o`/`rx_data_o` hold stable until accepted; next byte, if stored, appears the cycle after the pop.
- Back-to-back frames: IDLE re-entered at mid-stop bit, so the next start edge is never missed.

## Configuration
- `UART_RX_FIFO_EN` defined: FIFO of `FIFO_DEPTH` bytes, registered output (first-word-fall-through); `overrun_o` only when all `FIFO_DEPTH` entries are occupied.
- Undefined: single holding register; `overrun_o` whenever a byte completes while `rx_valid_o`=1 and `rx_ready_i`=0.

## Structure
- Shared package `uart_pkg`: FSM state encoding (IDLE, START, DATA, STOP, BREAK), default `CLKS_PER_BIT` constant 434, frame constants (8 data bits, 1 stop).
- One sub-module, `uart_rx_fifo`: synchronous FIFO with push/pop/full/empty, instantiated only under `UART_RX_FIFO_EN`.

## Test plan
- Send 0xC9, 0x03, 0x4A, 0xF6 at 8681 ns/bit, `rx_ready_i`=1 -> four valid pulses with exactly those bytes, no error pulses.
- 3 µs low glitch on the idle line -> no `rx_valid_o`, no `frame_err_o`; `busy_o` high for ~217 cycles then low; following 0x55 frame received correctly.
- Frame 0xA5 with the stop bit driven low, then the line held low 50 µs -> exactly one `frame_err_o` pulse, no byte; subsequent 0x3C received.
- `rx_ready_i`=0, send 0x11, 0x22 (+0x33, 0x44, 0x55 with FIFO) -> without FIFO: 0x11 held, one `overrun_o` on 0x22; with FIFO: 0x11–0x44 held, `overrun_o` on 0x55; release ready -> bytes popped in order.
- Assert `sw_rst_n` low during bit 4 of 0xF0 -> all outputs 0 immediately; after release, next 0x0F frame received intact.
- Completion and pop in the same cycle on a full store -> no `overrun_o`, new byte follows.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 serial receiver: receiver states, default bit
// timing for the 50 MHz board clock, and frame shape.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 434;
  localparam int DATA_BITS            = 8;
  localparam int STOP_BITS            = 1;
  localparam int FRAME_BITS           = 1 + DATA_BITS + STOP_BITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rxState_e;

  function automatic bit isPow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous byte FIFO with first-word-fall-through output, used by
// uart_rx_8n1 when UART_RX_FIFO_EN is defined.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [AW:0]      count_q;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rdPtr_q];

  // A pop frees the head slot in the same cycle, so a full FIFO may still accept a push.
  assign doPop  = pop_i & ~empty_o;
  assign doPush = push_i & (~full_o | doPop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= data_i;
        wrPtr_q        <= wrPtr_q + 1'b1;
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 serial receiver with valid/ready byte output, glitch, framing and overrun detection.
// Define UART_RX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-byte FIFO.
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_50m,
  input  logic       sw_rst_n,
  input  logic       uart_rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 8 || FIFO_DEPTH < 2 || !isPow2(FIFO_DEPTH)) begin : gBadParams
    $error("uart_rx_8n1: CLKS_PER_BIT must be >= 8 and FIFO_DEPTH a power of two >= 2");
  end

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic lineFall;

  // Two-flop synchronizer plus one history flop; all reset to the idle-high level.
  always_ff @(posedge clk_50m or negedge sw_rst_n) begin
    if (!sw_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign lineFall = prev_q & ~sync2_q;

  rxState_e         state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bitCnt_q;
  logic [7:0]       shift_q;
  logic             busy_q;
  logic             frameErr_q;
  logic [CNT_W-1:0] cntLast;
  logic             cntDone;
  logic             deliver;

  always_comb begin
    cntLast = FULL_LAST;
    if (state_q == ST_START) begin
      cntLast = HALF_LAST;
    end
  end

  assign cntDone = (cnt_q == cntLast);
  assign deliver = (state_q == ST_STOP) && cntDone && sync2_q;

  always_ff @(posedge clk_50m or negedge sw_rst_n) begin
    if (!sw_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      busy_q     <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      frameErr_q <= 1'b0;
      cnt_q      <= cntDone ? '0 : cnt_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (lineFall) begin
            state_q <= ST_START;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (cntDone) begin
            if (!sync2_q) begin
              state_q  <= ST_DATA;
              bitCnt_q <= '0;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (cntDone) begin
            shift_q  <= {sync2_q, shift_q[7:1]};
            bitCnt_q <= bitCnt_q + 1'b1;
            if (bitCnt_q == LAST_BIT) begin
              state_q <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          // Leaving at mid-stop-bit gives the next start edge half a bit of slack.
          if (cntDone) begin
            if (sync2_q) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              frameErr_q <= 1'b1;
              state_q    <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          cnt_q <= '0;
          if (sync2_q) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign frame_err_o = frameErr_q;
  assign busy_o      = busy_q;

`ifdef UART_RX_FIFO_EN

  logic fifoFull;
  logic fifoEmpty;
  logic fifoPush;
  logic fifoPop;
  logic overrun_q;

  assign fifoPop  = ~fifoEmpty & rx_ready_i;
  assign fifoPush = deliver & (~fifoFull | fifoPop);

  uart_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk_i   (clk_50m),
    .rst_ni  (sw_rst_n),
    .push_i  (fifoPush),
    .data_i  (shift_q),
    .pop_i   (fifoPop),
    .data_o  (rx_data_o),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  always_ff @(posedge clk_50m or negedge sw_rst_n) begin
    if (!sw_rst_n) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= deliver & fifoFull & ~fifoPop;
    end
  end

  assign rx_valid_o = ~fifoEmpty;
  assign overrun_o  = overrun_q;

`else

  logic [7:0] hold_q;
  logic [7:0] hold_d;
  logic       holdValid_q;
  logic       holdValid_d;
  logic       overrun_q;
  logic       overrun_d;
  logic       room;

  // A consumer pop in the completion cycle makes room for the new byte.
  always_comb begin
    hold_d      = hold_q;
    holdValid_d = holdValid_q;
    overrun_d   = 1'b0;
    room        = ~holdValid_q | rx_ready_i;
    if (holdValid_q && rx_ready_i) begin
      holdValid_d = 1'b0;
    end
    if (deliver) begin
      if (room) begin
        hold_d      = shift_q;
        holdValid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50m or negedge sw_rst_n) begin
    if (!sw_rst_n) begin
      hold_q      <= '0;
      holdValid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      holdValid_q <= holdValid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data_o  = hold_q;
  assign rx_valid_o = holdValid_q;
  assign overrun_o  = overrun_q;

`endif

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Bench for uart_rx_8n1: frame-level reference model of byte storage and pulses,
// compared every cycle, plus literal expectations for the directed scenarios.
module tb_uart_rx_8n1;

  localparam int C     = 32;
  localparam int HALF  = C / 2;
  localparam int DEPTH = 4;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic       clk;
  logic       rstN;
  logic       rxLine;
  logic       readyCmd;
  logic       randReady;
  logic       randBit;
  logic       rxReady;
  logic [7:0] rxData;
  logic       rxValid;
  logic       frameErr;
  logic       overrun;
  logic       busy;

  assign rxReady = randReady ? randBit : readyCmd;

  uart_rx_8n1 #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_50m     (clk),
    .sw_rst_n    (rstN),
    .uart_rx_i   (rxLine),
    .rx_data_o   (rxData),
    .rx_valid_o  (rxValid),
    .rx_ready_i  (rxReady),
    .frame_err_o (frameErr),
    .overrun_o   (overrun),
    .busy_o      (busy)
  );

  int         checks   = 0;
  int         errors   = 0;
  int         cyc      = 0;
  int         ferrSeen = 0;
  int         ovrSeen  = 0;
  logic [7:0] modelQ[$];
  logic [7:0] rxLog[$];
  int         evCycle[$];
  logic [7:0] evData[$];
  bit         evGood[$];
  bit         expFerr  = 0;
  bit         expOvr   = 0;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: a frame whose pin fell at cycle F has its stop sample at
  // F + 3 + C/2 + 9*C; a good stop delivers the byte into storage of CAP entries,
  // after any pop the consumer makes in that same cycle.
  initial forever begin
    @(posedge clk);
    cyc++;
    expFerr = 0;
    expOvr  = 0;
    if (!rstN) begin
      modelQ.delete();
      evCycle.delete();
      evData.delete();
      evGood.delete();
    end else begin
      if (modelQ.size() > 0 && rxReady) void'(modelQ.pop_front());
      while (evCycle.size() > 0 && evCycle[0] <= cyc) begin
        if (evGood[0]) begin
          if (modelQ.size() < CAP) modelQ.push_back(evData[0]);
          else expOvr = 1;
        end else begin
          expFerr = 1;
        end
        void'(evCycle.pop_front());
        void'(evData.pop_front());
        void'(evGood.pop_front());
      end
    end
  end

  initial forever begin
    @(negedge clk);
    #2;
    if (!rstN) begin
      checkOutput("resetValid", 32'(rxValid), 32'd0);
      checkOutput("resetData", 32'(rxData), 32'd0);
      checkOutput("resetFrameErr", 32'(frameErr), 32'd0);
      checkOutput("resetOverrun", 32'(overrun), 32'd0);
      checkOutput("resetBusy", 32'(busy), 32'd0);
    end else begin
      checkOutput("valid", 32'(rxValid), 32'(modelQ.size() > 0));
      if (modelQ.size() > 0) checkOutput("data", 32'(rxData), 32'(modelQ[0]));
      checkOutput("frameErr", 32'(frameErr), 32'(expFerr));
      checkOutput("overrun", 32'(overrun), 32'(expOvr));
      if (rxValid && rxReady) rxLog.push_back(rxData);
      if (frameErr) ferrSeen++;
      if (overrun) ovrSeen++;
    end
  end

  initial forever begin
    @(negedge clk);
    randBit = 1'($urandom_range(0, 1));
  end

  initial begin
    #1200000;
    errors++;
    $display("[TB] FAIL watchdog: actual=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame; popAtEnd raises ready only for the cycle of the stop sample.
  task automatic applyStimulus(input logic [7:0] b, input bit stopBit, input bit popAtEnd);
    int fall;
    int sampleCyc;
    @(negedge clk);
    rxLine    = 1'b0;
    fall      = cyc;
    sampleCyc = fall + 3 + HALF + 9 * C;
    evCycle.push_back(sampleCyc);
    evData.push_back(b);
    evGood.push_back(stopBit);
    repeat (C - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rxLine = b[i];
      repeat (C - 1) @(negedge clk);
    end
    @(negedge clk);
    rxLine = stopBit;
    for (int k = 1; k < C; k++) begin
      @(negedge clk);
      if (popAtEnd) begin
        if (cyc == sampleCyc - 1) readyCmd = 1'b1;
        else if (cyc == sampleCyc) readyCmd = 1'b0;
      end
    end
  endtask

  task automatic applyGlitch();
    int fall;
    @(negedge clk);
    rxLine = 1'b0;
    fall   = cyc;
    repeat (5) @(negedge clk);
    rxLine = 1'b1;
    while (cyc < fall + 10) @(negedge clk);
    #1;
    checkOutput("glitchBusyHigh", 32'(busy), 32'd1);
    while (cyc < fall + 3 + HALF + 3) @(negedge clk);
    #1;
    checkOutput("glitchBusyLow", 32'(busy), 32'd0);
    checkOutput("glitchNoValid", 32'(rxValid), 32'd0);
  endtask

  task automatic applyResetMidFrame(input logic [7:0] b);
    @(negedge clk);
    rxLine = 1'b0;
    repeat (C - 1) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rxLine = b[i];
      repeat (C - 1) @(negedge clk);
    end
    @(negedge clk);
    rxLine = b[4];
    repeat (HALF) @(negedge clk);
    #1;
    checkOutput("midFrameBusy", 32'(busy), 32'd1);
    rstN   = 1'b0;
    rxLine = 1'b1;
    #1;
    checkOutput("midResetValid", 32'(rxValid), 32'd0);
    checkOutput("midResetData", 32'(rxData), 32'd0);
    checkOutput("midResetBusy", 32'(busy), 32'd0);
    checkOutput("midResetFrameErr", 32'(frameErr), 32'd0);
    checkOutput("midResetOverrun", 32'(overrun), 32'd0);
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    idleCycles(2 * C);
  endtask

  initial begin
    logic [7:0] t1Bytes [4];
    int         base;
    int         f0;
    int         o0;
    logic [7:0] b;
    bit         stopOk;

    t1Bytes[0] = 8'hC9;
    t1Bytes[1] = 8'h03;
    t1Bytes[2] = 8'h4A;
    t1Bytes[3] = 8'hF6;
    rstN      = 1'b0;
    rxLine    = 1'b1;
    readyCmd  = 1'b1;
    randReady = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("initValid", 32'(rxValid), 32'd0);
    checkOutput("initData", 32'(rxData), 32'd0);
    checkOutput("initBusy", 32'(busy), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    idleCycles(C);

    $display("[TB] four frames with ready held high");
    base = rxLog.size();
    for (int i = 0; i < 4; i++) applyStimulus(t1Bytes[i], 1'b1, 1'b0);
    idleCycles(2 * C);
    checkOutput("t1Count", 32'(rxLog.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (rxLog.size() > base + i) checkOutput("t1Byte", 32'(rxLog[base + i]), 32'(t1Bytes[i]));
    end
    checkOutput("t1NoFrameErr", 32'(ferrSeen), 32'd0);
    checkOutput("t1NoOverrun", 32'(ovrSeen), 32'd0);

    $display("[TB] start-bit glitch then 0x55");
    base = rxLog.size();
    applyGlitch();
    idleCycles(C);
    applyStimulus(8'h55, 1'b1, 1'b0);
    idleCycles(2 * C);
    checkOutput("glitchThenCount", 32'(rxLog.size() - base), 32'd1);
    if (rxLog.size() > base) checkOutput("glitchThenByte", 32'(rxLog[base]), 32'h55);

    $display("[TB] low stop bit and held-low line");
    f0   = ferrSeen;
    base = rxLog.size();
    applyStimulus(8'hA5, 1'b0, 1'b0);
    idleCycles(3 * C);
    rxLine = 1'b1;
    idleCycles(2 * C);
    applyStimulus(8'h3C, 1'b1, 1'b0);
    idleCycles(2 * C);
    checkOutput("breakErrPulses", 32'(ferrSeen - f0), 32'd1);
    checkOutput("breakCount", 32'(rxLog.size() - base), 32'd1);
    if (rxLog.size() > base) checkOutput("breakNextByte", 32'(rxLog[base]), 32'h3C);

    $display("[TB] overrun with consumer stalled");
    o0       = ovrSeen;
    base     = rxLog.size();
    readyCmd = 1'b0;
    for (int i = 0; i <= CAP; i++) applyStimulus(8'(8'h11 * (i + 1)), 1'b1, 1'b0);
    idleCycles(C);
    checkOutput("ovrHeldValid", 32'(rxValid), 32'd1);
    checkOutput("ovrHeldData", 32'(rxData), 32'h11);
    checkOutput("ovrPulses", 32'(ovrSeen - o0), 32'd1);
    readyCmd = 1'b1;
    idleCycles(C);
    checkOutput("ovrDrainCount", 32'(rxLog.size() - base), 32'(CAP));
    for (int i = 0; i < CAP; i++) begin
      if (rxLog.size() > base + i) checkOutput("ovrDrainByte", 32'(rxLog[base + i]), 32'(8'(8'h11 * (i + 1))));
    end

    $display("[TB] reset during bit 4");
    base = rxLog.size();
    applyResetMidFrame(8'hF0);
    applyStimulus(8'h0F, 1'b1, 1'b0);
    idleCycles(2 * C);
    checkOutput("postResetCount", 32'(rxLog.size() - base), 32'd1);
    if (rxLog.size() > base) checkOutput("postResetByte", 32'(rxLog[base]), 32'h0F);

    $display("[TB] completion and pop in the same cycle on a full store");
    o0       = ovrSeen;
    base     = rxLog.size();
    readyCmd = 1'b0;
    for (int i = 0; i < CAP; i++) applyStimulus(8'(8'hA0 + i), 1'b1, 1'b0);
    applyStimulus(8'h77, 1'b1, 1'b1);
    idleCycles(C);
    checkOutput("sameCycleNoOverrun", 32'(ovrSeen - o0), 32'd0);
    readyCmd = 1'b1;
    idleCycles(C);
    checkOutput("sameCycleCount", 32'(rxLog.size() - base), 32'(CAP + 1));
    if (rxLog.size() > base) checkOutput("sameCycleFirst", 32'(rxLog[base]), 32'hA0);
    if (rxLog.size() > 0) checkOutput("sameCycleLast", 32'(rxLog[rxLog.size() - 1]), 32'h77);

    $display("[TB] randomized frames with random ready");
    randReady = 1'b1;
    for (int n = 0; n < 12; n++) begin
      b      = 8'($urandom_range(0, 255));
      stopOk = ($urandom_range(0, 7) != 0);
      applyStimulus(b, stopOk, 1'b0);
      if (!stopOk) begin
        rxLine = 1'b1;
        idleCycles(C);
      end
      idleCycles($urandom_range(0, C));
    end
    randReady = 1'b0;
    readyCmd  = 1'b1;
    idleCycles(3 * C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
